bmem_responder: RTL

- Synthesizable responder for the banked-memory port driven by the cpu top (`bmem_addr`/`read`/`write`/`wdata`/`ready`/`raddr`/`rdata`/`rvalid`).
- Accepts 4-beat line reads and writes against an on-chip backing store, with one outstanding read per bank.
- Returns read bursts after a fixed minimum latency; bursts from different banks may complete out of order.
- Used as an FPGA/emulation stand-in for the behavioural banked memory, and as a DUT-side loopback for cache adapter benches.

---
 rtl/bmem_pkg.sv | 35 +++
 rtl/bmem_rr_arbiter.sv | 40 ++++
 rtl/bmem_responder.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/bmem_pkg.sv
// Shared widths, slot record and write-FSM states for the banked-memory responder.
package bmem_pkg;

    localparam int BMEM_ADDR_W       = 32;
    localparam int BMEM_DATA_W       = 64;
    localparam int BMEM_BURST_LEN    = 4;
    localparam int BMEM_NUM_BANKS    = 4;
    localparam int BMEM_DEPTH_LINES  = 256;
    localparam int BMEM_READ_LATENCY = 8;

    localparam int BMEM_LINE_BYTES = BMEM_BURST_LEN * BMEM_DATA_W / 8;
    localparam int BMEM_LINE_LSB   = $clog2(BMEM_LINE_BYTES);
    localparam int BMEM_BANK_W     = $clog2(BMEM_NUM_BANKS);
    localparam int BMEM_INDEX_W    = $clog2(BMEM_DEPTH_LINES);
    localparam int BMEM_BEAT_W     = $clog2(BMEM_BURST_LEN);
    localparam int BMEM_CNT_W      = $clog2(BMEM_READ_LATENCY);

    typedef logic [BMEM_BURST_LEN-1:0][BMEM_DATA_W-1:0] bmem_line_t;

    typedef struct packed {
        logic                   valid;
        logic [BMEM_ADDR_W-1:0] line_addr;
        logic [BMEM_CNT_W-1:0]  counter;
        bmem_line_t             data;
    } bmem_slot_t;

    // State ordinal doubles as the beat index written in that state.
    typedef enum logic [BMEM_BEAT_W-1:0] {
        W_IDLE  = 2'd0,
        W_BEAT1 = 2'd1,
        W_BEAT2 = 2'd2,
        W_BEAT3 = 2'd3
    } bmem_wstate_e;

endpackage

// File: rtl/bmem_rr_arbiter.sv
// Round-robin grant over N requesters; the pointer moves to the slot after each grant.
module bmem_rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         i_req,
    input  logic                 i_en,
    output logic                 o_valid,
    output logic [$clog2(N)-1:0] o_idx
);

    localparam int IDX_W = $clog2(N);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_k;

    // Scan from lowest to highest priority so the last hit is the winner.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = r_ptr;
        w_k     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            w_k = IDX_W'((int'(r_ptr) + i) % N);
            if (i_req[w_k]) begin
                o_valid = i_en;
                o_idx   = w_k;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (o_valid) begin
            r_ptr <= (o_idx == IDX_W'(N - 1)) ? '0 : o_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/bmem_responder.sv
// Banked-memory responder: 4-beat line writes into an on-chip store, one pending
// read per bank, bursts returned in round-robin order after a fixed latency.
module bmem_responder
    import bmem_pkg::*;
#(
    parameter int ADDR_WIDTH   = BMEM_ADDR_W,
    parameter int DATA_WIDTH   = BMEM_DATA_W,
    parameter int BURST_LEN    = BMEM_BURST_LEN,
    parameter int NUM_BANKS    = BMEM_NUM_BANKS,
    parameter int DEPTH_LINES  = BMEM_DEPTH_LINES,
    parameter int READ_LATENCY = BMEM_READ_LATENCY
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] bmem_addr,
    input  logic                  bmem_read,
    input  logic                  bmem_write,
    input  logic [DATA_WIDTH-1:0] bmem_wdata,
    output logic                  bmem_ready,
    output logic [ADDR_WIDTH-1:0] bmem_raddr,
    output logic [DATA_WIDTH-1:0] bmem_rdata,
    output logic                  bmem_rvalid,
    output logic                  error
);

    localparam int LAST_BEAT = BURST_LEN - 1;

    bmem_line_t   r_store [DEPTH_LINES];
    bmem_slot_t   r_slot  [NUM_BANKS];
    bmem_wstate_e r_wstate, w_wnext;

    logic [BMEM_INDEX_W-1:0] r_wline;
    logic                    r_error;
    logic                    r_rvalid;
    logic [BMEM_BANK_W-1:0]  r_rbank;
    logic [BMEM_BEAT_W-1:0]  r_rbeat;
    logic [ADDR_WIDTH-1:0]   r_raddr;
    logic [DATA_WIDTH-1:0]   r_rdata;

    logic [BMEM_BANK_W-1:0]  w_bank;
    logic [BMEM_INDEX_W-1:0] w_line;
    logic                    w_aligned;
    logic                    w_ready;
    logic                    w_rd_accept;
    logic                    w_we;
    logic [BMEM_INDEX_W-1:0] w_we_line;
    logic [BMEM_BEAT_W-1:0]  w_we_beat;
    logic                    w_err;
    logic                    w_burst_done;
    logic [BMEM_BEAT_W-1:0]  w_next_beat;
    logic [NUM_BANKS-1:0]    w_eligible;
    logic                    w_grant_valid;
    logic [BMEM_BANK_W-1:0]  w_grant_idx;

    assign w_bank       = bmem_addr[BMEM_LINE_LSB +: BMEM_BANK_W];
    assign w_line       = bmem_addr[BMEM_LINE_LSB +: BMEM_INDEX_W];
    assign w_aligned    = (bmem_addr[BMEM_LINE_LSB-1:0] == '0);
    assign w_we_beat    = r_wstate;
    assign w_burst_done = r_rvalid && (r_rbeat == BMEM_BEAT_W'(LAST_BEAT));
    assign w_next_beat  = r_rbeat + BMEM_BEAT_W'(1);

    // Request decode; ready is forced low while reset is held so nothing reaches the store.
    always_comb begin
        w_wnext     = r_wstate;
        w_ready     = 1'b0;
        w_rd_accept = 1'b0;
        w_we        = 1'b0;
        w_we_line   = r_wline;
        w_err       = 1'b0;
        if (rst_n) begin
            case (r_wstate)
                W_IDLE: begin
                    w_ready = !r_slot[w_bank].valid;
                    if (bmem_read && bmem_write) begin
                        w_err = 1'b1;
                    end else if ((bmem_read || bmem_write) && !w_aligned) begin
                        w_err = 1'b1;
                    end else if (bmem_read && w_ready) begin
                        w_rd_accept = 1'b1;
                    end else if (bmem_write && w_ready) begin
                        w_we      = 1'b1;
                        w_we_line = w_line;
                        w_wnext   = W_BEAT1;
                    end
                end
                default: begin
                    w_ready = 1'b1;
                    if (bmem_read) begin
                        w_err = 1'b1;
                    end
                    if (bmem_write && !bmem_read) begin
                        w_we    = 1'b1;
                        w_wnext = (r_wstate == W_BEAT3) ? W_IDLE
                                                        : bmem_wstate_e'(r_wstate + BMEM_BEAT_W'(1));
                    end else if (!bmem_write) begin
                        w_err   = 1'b1;
                        w_wnext = W_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wstate <= W_IDLE;
            r_wline  <= '0;
            r_error  <= 1'b0;
        end else begin
            r_wstate <= w_wnext;
            r_error  <= r_error | w_err;
            if (w_we && r_wstate == W_IDLE) begin
                r_wline <= w_line;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_store[w_we_line][w_we_beat] <= bmem_wdata;
        end
    end

    // Counter is loaded two short because the grant cycle adds one before the first beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                r_slot[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (r_slot[b].valid && r_slot[b].counter != '0) begin
                    r_slot[b].counter <= r_slot[b].counter - BMEM_CNT_W'(1);
                end
                if (w_burst_done && r_rbank == BMEM_BANK_W'(b)) begin
                    r_slot[b].valid <= 1'b0;
                end
                if (w_rd_accept && w_bank == BMEM_BANK_W'(b)) begin
                    r_slot[b].valid     <= 1'b1;
                    r_slot[b].line_addr <= bmem_addr;
                    r_slot[b].counter   <= BMEM_CNT_W'(READ_LATENCY - 2);
                    r_slot[b].data      <= r_store[w_line];
                end
            end
        end
    end

    always_comb begin
        w_eligible = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_eligible[b] = r_slot[b].valid && (r_slot[b].counter == '0);
        end
    end

    bmem_rr_arbiter #(
        .N (NUM_BANKS)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_req   (w_eligible),
        .i_en    (!r_rvalid),
        .o_valid (w_grant_valid),
        .o_idx   (w_grant_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= 1'b0;
            r_rbank  <= '0;
            r_rbeat  <= '0;
            r_raddr  <= '0;
            r_rdata  <= '0;
        end else if (!r_rvalid) begin
            if (w_grant_valid) begin
                r_rvalid <= 1'b1;
                r_rbank  <= w_grant_idx;
                r_rbeat  <= '0;
                r_raddr  <= r_slot[w_grant_idx].line_addr;
                r_rdata  <= r_slot[w_grant_idx].data[0];
            end
        end else if (w_burst_done) begin
            r_rvalid <= 1'b0;
        end else begin
            r_rbeat <= w_next_beat;
            r_rdata <= r_slot[r_rbank].data[w_next_beat];
        end
    end

    assign bmem_ready  = w_ready;
    assign bmem_rvalid = r_rvalid;
    assign bmem_raddr  = r_raddr;
    assign bmem_rdata  = r_rdata;
    assign error       = r_error;

endmodule
